// File: rtl/scroll_engine.sv
// Scroll engine: synchronizes the slow scroll clock into clk_in and advances a circular
// message window onto active-low seven-segment digits. Define SCROLL_REV_EN for the dir input.
module scroll_engine #(
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIGITS = 6,
    parameter int CHAR_W     = 5
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        scroll_clk,
    input  logic                        enable,
`ifdef SCROLL_REV_EN
    input  logic                        dir,
`endif
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [CHAR_W-1:0]           wr_data,
    output logic [NUM_DIGITS*7-1:0]     seg_out,
    output logic [$clog2(MSG_LEN)-1:0]  pos,
    output logic                        step_pulse
);

    localparam int              AW      = $clog2(MSG_LEN);
    localparam logic [AW:0]     LEN_EXT = (AW+1)'(MSG_LEN);
    localparam logic [AW-1:0]   LAST    = AW'(MSG_LEN - 1);

    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              chain_valid;
    logic              armed;
    logic [AW-1:0]     next_pos;
    logic [CHAR_W-1:0] msg_buf [MSG_LEN];
    logic [NUM_DIGITS*7-1:0] seg_next;
    logic [AW:0]       slot;

    function automatic logic [6:0] decode(input logic [CHAR_W-1:0] code);
        logic [6:0] seg;
        case (int'(code))
            0:       seg = 7'h40;
            1:       seg = 7'h79;
            2:       seg = 7'h24;
            3:       seg = 7'h30;
            4:       seg = 7'h19;
            5:       seg = 7'h12;
            6:       seg = 7'h02;
            7:       seg = 7'h78;
            8:       seg = 7'h00;
            9:       seg = 7'h10;
            10:      seg = 7'h08;
            11:      seg = 7'h03;
            12:      seg = 7'h46;
            13:      seg = 7'h21;
            14:      seg = 7'h06;
            15:      seg = 7'h0E;
            17:      seg = 7'h3F;
            18:      seg = 7'h09;
            19:      seg = 7'h47;
            20:      seg = 7'h0C;
            21:      seg = 7'h41;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // armed only after a genuine low sample, so a scroll_clk already high at reset release is not a step
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            chain_valid <= 1'b0;
            armed       <= 1'b0;
            step_pulse  <= 1'b0;
        end else begin
            sync1       <= scroll_clk;
            sync2       <= sync1;
            hist        <= sync2;
            chain_valid <= 1'b1;
            if (chain_valid && !sync1)
                armed <= 1'b1;
            step_pulse  <= sync2 & ~hist & armed;
        end
    end

    always_comb begin
        next_pos = (pos == LAST) ? '0 : pos + 1'b1;
`ifdef SCROLL_REV_EN
        if (dir)
            next_pos = (pos == '0) ? LAST : pos - 1'b1;
`endif
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pos <= '0;
            for (int unsigned i = 0; i < MSG_LEN; i++)
                msg_buf[i] <= CHAR_W'(16);
        end else begin
            if (step_pulse && enable)
                pos <= next_pos;
            if (wr_en && ({1'b0, wr_addr} < LEN_EXT))
                msg_buf[wr_addr] <= wr_data;
        end
    end

    // digit i shows slot (pos+i) mod MSG_LEN; i < MSG_LEN so one subtraction suffices
    always_comb begin
        seg_next = '1;
        slot     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            slot = {1'b0, pos} + (AW+1)'(i);
            if (slot >= LEN_EXT)
                slot = slot - LEN_EXT;
            seg_next[(NUM_DIGITS-i)*7-1 -: 7] = decode(msg_buf[slot[AW-1:0]]);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)
            seg_out <= '1;
        else
            seg_out <= seg_next;
    end

endmodule

// File: tb/tb_scroll_engine.sv
// Scoreboard bench for scroll_engine: stimulus queues expected steps/snapshots, a negedge monitor checks them.
module tb_scroll_engine;

    localparam int MSG_LEN    = 16;
    localparam int NUM_DIGITS = 6;
    localparam int CHAR_W     = 5;
    localparam int AW         = 4;

    logic                    clk_in     = 1'b0;
    logic                    reset      = 1'b0;
    logic                    scroll_clk = 1'b0;
    logic                    enable     = 1'b1;
`ifdef SCROLL_REV_EN
    logic                    dir        = 1'b0;
`endif
    logic                    wr_en      = 1'b0;
    logic [AW-1:0]           wr_addr    = '0;
    logic [CHAR_W-1:0]       wr_data    = '0;
    logic [NUM_DIGITS*7-1:0] seg_out;
    logic [AW-1:0]           pos;
    logic                    step_pulse;

    scroll_engine #(
        .MSG_LEN    (MSG_LEN),
        .NUM_DIGITS (NUM_DIGITS),
        .CHAR_W     (CHAR_W)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .scroll_clk (scroll_clk),
        .enable     (enable),
`ifdef SCROLL_REV_EN
        .dir        (dir),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .seg_out    (seg_out),
        .pos        (pos),
        .step_pulse (step_pulse)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        logic [AW-1:0] pos;
        int unsigned   cyc;
    } step_t;

    typedef struct {
        logic [AW-1:0] pos;
        logic [6:0]    d0;
        logic [6:0]    d5;
        bit            blank;
    } snap_t;

    localparam logic [NUM_DIGITS*7-1:0] ALL_BLANK = '1;

    step_t       step_q[$];
    snap_t       snap_q[$];
    string       snap_name_q[$];
    step_t       s_item;
    snap_t       n_item;
    string       n_name;
    int          checks    = 0;
    int          failures  = 0;
    int unsigned cyc       = 0;
    logic        snap      = 1'b0;
    logic        prev_step = 1'b0;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (prev_step) begin
            checks++;
            if (step_pulse !== 1'b0) begin
                failures++;
                $display("FAIL pulse_width: step_pulse=%b required 0", step_pulse);
            end
        end
        if (step_pulse === 1'b1) begin
            if (step_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_step: cycle %0d pos=%0d, no step required", cyc, pos);
            end else begin
                s_item = step_q.pop_front();
                checks += 2;
                if (pos !== s_item.pos) begin
                    failures++;
                    $display("FAIL step_pos: got %0d required %0d", pos, s_item.pos);
                end
                if (cyc != s_item.cyc) begin
                    failures++;
                    $display("FAIL step_latency: pulse at cycle %0d required %0d", cyc, s_item.cyc);
                end
            end
        end
        prev_step = (step_pulse === 1'b1);
        if (snap && snap_q.size() != 0) begin
            n_item = snap_q.pop_front();
            n_name = snap_name_q.pop_front();
            checks++;
            if (pos !== n_item.pos) begin
                failures++;
                $display("FAIL %s pos: got %0d required %0d", n_name, pos, n_item.pos);
            end
            if (n_item.blank) begin
                checks++;
                if (seg_out !== ALL_BLANK) begin
                    failures++;
                    $display("FAIL %s seg_out: got %h required %h", n_name, seg_out, ALL_BLANK);
                end
            end else begin
                checks += 2;
                if (seg_out[NUM_DIGITS*7-1 -: 7] !== n_item.d0) begin
                    failures++;
                    $display("FAIL %s digit0: got %h required %h", n_name, seg_out[NUM_DIGITS*7-1 -: 7], n_item.d0);
                end
                if (seg_out[6:0] !== n_item.d5) begin
                    failures++;
                    $display("FAIL %s digit5: got %h required %h", n_name, seg_out[6:0], n_item.d5);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic expect_snap(input string name, input logic [AW-1:0] p,
                               input logic [6:0] d0, input logic [6:0] d5, input bit blank);
        snap_q.push_back('{pos: p, d0: d0, d5: d5, blank: blank});
        snap_name_q.push_back(name);
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
    endtask

    // pulse expected after the 3rd edge past the sampling edge; an optional write lands in the step cycle
    task automatic do_step(input logic [AW-1:0] p_before, input bit wr,
                           input logic [AW-1:0] wa, input logic [CHAR_W-1:0] wd);
        step_q.push_back('{pos: p_before, cyc: cyc + 3});
        scroll_clk = 1'b1;
        tick(3);
        if (wr) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        tick(1);
        wr_en = 1'b0;
        tick(2);
        scroll_clk = 1'b0;
        tick(4);
    endtask

    initial begin
        tick(3);
        expect_snap("reset_held", 4'd0, 7'h7F, 7'h7F, 1'b1);
        reset = 1'b1;
        tick(10);
        expect_snap("after_release", 4'd0, 7'h7F, 7'h7F, 1'b1);

        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = CHAR_W'(i);
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
        expect_snap("load", 4'd0, 7'h40, 7'h12, 1'b0);

        do_step(4'd0, 1'b0, '0, '0);
        expect_snap("single_step", 4'd1, 7'h79, 7'h02, 1'b0);

        for (int p = 1; p < 12; p++)
            do_step(AW'(p), 1'b0, '0, '0);
        expect_snap("pos12", 4'd12, 7'h46, 7'h79, 1'b0);
        for (int p = 12; p < 16; p++)
            do_step(AW'(p), 1'b0, '0, '0);
        expect_snap("wrap", 4'd0, 7'h40, 7'h12, 1'b0);

        enable = 1'b0;
        for (int k = 0; k < 3; k++)
            do_step(4'd0, 1'b0, '0, '0);
        expect_snap("enable_off", 4'd0, 7'h40, 7'h12, 1'b0);

        enable = 1'b1;
        do_step(4'd0, 1'b1, 4'd1, 5'd17);
        expect_snap("step_write", 4'd1, 7'h3F, 7'h02, 1'b0);

        for (int p = 1; p < 7; p++)
            do_step(AW'(p), 1'b0, '0, '0);
        expect_snap("pos7", 4'd7, 7'h78, 7'h46, 1'b0);

        scroll_clk = 1'b1;
        tick(2);
        reset = 1'b0;
        expect_snap("mid_reset", 4'd0, 7'h7F, 7'h7F, 1'b1);
        scroll_clk = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(6);
        expect_snap("post_reset", 4'd0, 7'h7F, 7'h7F, 1'b1);

        reset = 1'b0;
        scroll_clk = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(10);
        scroll_clk = 1'b0;
        tick(4);
        expect_snap("high_at_release", 4'd0, 7'h7F, 7'h7F, 1'b1);
        do_step(4'd0, 1'b0, '0, '0);
        expect_snap("step_after_reset", 4'd1, 7'h7F, 7'h7F, 1'b1);

`ifdef SCROLL_REV_EN
        dir = 1'b1;
        do_step(4'd1, 1'b0, '0, '0);
        do_step(4'd0, 1'b0, '0, '0);
        expect_snap("rev_wrap", 4'd15, 7'h7F, 7'h7F, 1'b1);
        dir = 1'b0;
`endif

        tick(5);
        while (step_q.size() != 0) begin
            s_item = step_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_step: no pulse seen, required one at cycle %0d", s_item.cyc);
        end
        while (snap_q.size() != 0) begin
            void'(snap_q.pop_front());
            n_name = snap_name_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: snapshot not sampled, required sampled", n_name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
